// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: sequential PC generator, valid/ack memory request channel
// and DEPTH-entry prefetch FIFO feeding decode. Optional misaligned-fetch trap: IF_ALIGN_CHECK_EN.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic              out_adel
`endif
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [31:0]       r_inst_mem [DEPTH];

  logic              w_xfer;
  logic              w_push;
  logic              w_pop;
  logic              w_block;
  logic [31:0]       w_push_inst;
  logic [ADDR_W-1:0] w_redirect_fetch;
  logic [ADDR_W-1:0] w_reset_fetch;

`ifdef IF_ALIGN_CHECK_EN
  logic r_halted;
  logic r_adel_pend;
  logic r_adel_mem [DEPTH];

  // A misaligned target keeps its low bits so the trap entry reports the faulting PC.
  assign w_redirect_fetch = redirect_pc;
  assign w_reset_fetch    = RESET_PC;
  assign w_block          = r_halted || r_adel_pend;
  assign w_push           = w_xfer || (r_adel_pend && !redirect_valid);
  assign w_push_inst      = r_adel_pend ? 32'h0 : imem_rdata;
`else
  assign w_redirect_fetch = redirect_pc & WORD_MSK;
  assign w_reset_fetch    = RESET_PC & WORD_MSK;
  assign w_block          = 1'b0;
  assign w_push           = w_xfer;
  assign w_push_inst      = imem_rdata;
`endif

  // Request is gated by rstn so it stays low throughout reset and rises as soon as reset lifts.
  assign imem_req  = rstn && !redirect_valid && (r_count != FULL_CNT) && !w_block;
  assign imem_addr = r_fetch_pc & WORD_MSK;
  assign w_xfer    = imem_req && imem_ack;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready && !redirect_valid;
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign out_inst  = out_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
`ifdef IF_ALIGN_CHECK_EN
  assign out_adel  = out_valid ? r_adel_mem[r_rd_ptr] : 1'b0;
`endif

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CNT_W'(1);
    else if (w_pop && !w_push)
      w_count_nxt = r_count - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_pc <= w_reset_fetch;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_fetch;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_xfer) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      if (w_push) r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_halted    <= 1'b0;
      r_adel_pend <= (RESET_PC[1:0] != 2'b00);
    end else if (redirect_valid) begin
      r_halted    <= 1'b0;
      r_adel_pend <= (redirect_pc[1:0] != 2'b00);
    end else if (r_adel_pend) begin
      r_halted    <= 1'b1;
      r_adel_pend <= 1'b0;
    end
  end
`endif

  // NOTE: FIFO storage has no reset; out_* are masked to zero while empty, so stale contents never show.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_inst_mem[r_wr_ptr] <= w_push_inst;
`ifdef IF_ALIGN_CHECK_EN
      r_adel_mem[r_wr_ptr] <= r_adel_pend;
`endif
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed-vector bench for if_prefetch_unit; instruction memory returns word index (addr>>2).
// Build with +define+IF_ALIGN_CHECK_EN to exercise the misaligned-fetch trap.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef IF_ALIGN_CHECK_EN
  logic        out_adel;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {2'b00, imem_addr[31:2]};

  if_prefetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .out_adel       (out_adel)
`endif
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic ack,
                              input logic rdy, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc, input logic [31:0] inst,
                              input logic adel);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdy = rdy;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.inst = inst; v.adel = adel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs driven just after the falling edge, outputs sampled 1ns later, then advance a cycle.
  task automatic apply(input vec_t v, input string tag);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    imem_ack       = v.ack;
    out_ready      = v.rdy;
    #1;
    check({tag, " imem_req"},  32'(imem_req),  32'(v.req));
    check({tag, " imem_addr"}, imem_addr,      v.addr);
    check({tag, " out_valid"}, 32'(out_valid), 32'(v.vld));
    check({tag, " out_pc"},    out_pc,         v.pc);
    check({tag, " out_inst"},  out_inst,       v.inst);
`ifdef IF_ALIGN_CHECK_EN
    check({tag, " out_adel"},  32'(out_adel),  32'(v.adel));
`endif
    @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    // Reset release, ack stall, streaming, back-pressure, redirect, redirect on a full FIFO.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0, 1,  1, 32'h0,   0, 32'h0,   32'h0,  0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h0,   0, 32'h0,   32'h0,  0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h4,   1, 32'h0,   32'h0,  0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h8,   1, 32'h4,   32'h1,  0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'hC,   1, 32'h8,   32'h2,  0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 32'h10,  1, 32'hC,   32'h3,  0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 32'h14,  1, 32'hC,   32'h3,  0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 32'h18,  1, 32'hC,   32'h3,  0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, 0, 1, 0, 0, 32'h1C,  1, 32'hC,   32'h3,  0));
    tbl.push_back(mk(0, 0, 1, 1,  0, 32'h1C,  1, 32'hC,   32'h3,  0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h1C,  1, 32'h10,  32'h4,  0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h20,  1, 32'h14,  32'h5,  0));
    tbl.push_back(mk(1, 32'h100, 1, 1, 0, 32'h24, 1, 32'h18, 32'h6, 0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h100, 0, 32'h0,   32'h0,  0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h104, 1, 32'h100, 32'h40, 0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h108, 1, 32'h104, 32'h41, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 32'h10C, 1, 32'h108, 32'h42, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 32'h110, 1, 32'h108, 32'h42, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 32'h114, 1, 32'h108, 32'h42, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 32'h118, 1, 32'h108, 32'h42, 0));
    tbl.push_back(mk(1, 32'h300, 1, 1, 0, 32'h118, 1, 32'h108, 32'h42, 0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h300, 0, 32'h0,   32'h0,  0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 32'h304, 1, 32'h300, 32'hC0, 0));

    // PC wrap-around at the top of the address space.
    seq.push_back(mk(1, 32'hFFFF_FFFC, 1, 1, 0, 32'h308, 1, 32'h304, 32'hC1, 0));
    seq.push_back(mk(0, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0));
    seq.push_back(mk(0, 0, 1, 1, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 0));
    seq.push_back(mk(0, 0, 1, 1, 1, 32'h4, 1, 32'h0, 32'h0, 0));
    // Misaligned redirect target.
    seq.push_back(mk(1, 32'h102, 1, 1, 0, 32'h8, 1, 32'h4, 32'h1, 0));
`ifdef IF_ALIGN_CHECK_EN
    seq.push_back(mk(0, 0, 1, 1, 0, 32'h100, 0, 32'h0,   32'h0, 0));
    seq.push_back(mk(0, 0, 1, 1, 0, 32'h100, 1, 32'h102, 32'h0, 1));
    seq.push_back(mk(0, 0, 1, 1, 0, 32'h100, 0, 32'h0,   32'h0, 0));
    seq.push_back(mk(0, 0, 1, 1, 0, 32'h100, 0, 32'h0,   32'h0, 0));
    seq.push_back(mk(1, 32'h200, 1, 1, 0, 32'h100, 0, 32'h0, 32'h0, 0));
    seq.push_back(mk(0, 0, 1, 1, 1, 32'h200, 0, 32'h0,   32'h0, 0));
    seq.push_back(mk(0, 0, 1, 1, 1, 32'h204, 1, 32'h200, 32'h80, 0));
`else
    seq.push_back(mk(0, 0, 1, 1, 1, 32'h100, 0, 32'h0,   32'h0,  0));
    seq.push_back(mk(0, 0, 1, 1, 1, 32'h104, 1, 32'h100, 32'h40, 0));
`endif

    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ack       = 1'b0;
    out_ready      = 1'b1;
    #1;
    check("reset imem_req",  32'(imem_req),  32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_pc",    out_pc,         32'h0);
    check("reset out_inst",  out_inst,       32'h0);
    check("reset imem_addr", imem_addr,      32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));
    foreach (seq[i]) apply(seq[i], $sformatf("seq[%0d]", i));

    // Asynchronous reset mid-operation with entries buffered and a request pending.
    #3 rstn = 1'b0;
    #1;
    check("async rst imem_req",  32'(imem_req),  32'h0);
    check("async rst out_valid", 32'(out_valid), 32'h0);
    check("async rst out_pc",    out_pc,         32'h0);
    check("async rst imem_addr", imem_addr,      32'h0);
    @(negedge clk);
    rstn = 1'b1;
    apply(mk(0, 0, 0, 1, 1, 32'h0, 0, 32'h0, 32'h0, 0), "post-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Parametrised instruction-fetch front end for the cqu_mips five-stage pipeline. It replaces the single-register fetch stage with a sequential PC generator, a valid/ack request channel to external instruction memory, and a DEPTH-entry prefetch FIFO. Redirects from branch/jump resolution flush the FIFO. The decode stage consumes {pc, inst} pairs through a valid/ready handshake, so back-pressure replaces the old stall input.

## Interface
- ADDR_W, 32, PC / memory address width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset (ADDR_W bits)

- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address; word-aligned
- imem_ack  in  1  memory accepts request; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_pc  out  ADDR_W  PC of head instruction
- out_inst  out  32  head instruction
- out_adel  out  1  head is a misaligned-fetch exception (only with IF_ALIGN_CHECK_EN; tie-off absent otherwise)

## Operation
- fetch_pc register drives imem_addr; imem_req = !redirect_valid && (count < DEPTH) && !halted.
- Transfer = imem_req && imem_ack: push {fetch_pc, imem_rdata} into FIFO; fetch_pc += 4 (wraps modulo 2^ADDR_W).
- imem_addr/imem_req hold stable until transfer or redirect.
- Pop = out_valid && out_ready; out_* show FIFO head; out_valid = (count != 0).
- Simultaneous push and pop: count unchanged, both take effect.
- Redirect (highest priority): FIFO emptied, count=0, fetch_pc <= redirect_pc, halted cleared. Any pop in that cycle is discarded. No transfer occurs because imem_req is forced low.
- Count width $clog2(DEPTH+1); pointers $clog2(DEPTH), wrap naturally.
- Full (count==DEPTH): imem_req low; no push. Empty: out_valid low; out_pc/out_inst hold 0.

## Timing
- Reset: fetch_pc=RESET_PC, count=0, halted=0, out_valid=0, out_pc=0, out_inst=0, out_adel=0, imem_req=0 while rstn low. imem_req rises combinationally once rstn is released.
- Latency: transfer in cycle N → out_valid in cycle N+1. There is no bypass.
- Throughput: 1 instruction/cycle with imem_ack tied high and out_ready high.
- Redirect asserted in cycle N: out_valid=0 in N+1. First request to redirect_pc is presented in N+1.
- Reset asserted mid-operation clears all state asynchronously. A pending request is abandoned and memory must not expect completion.

## Configuration
- IF_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 does not issue a request.
  - The next cycle pushes one FIFO entry {redirect_pc, 32'h0} with out_adel=1 and sets halted.
  - No further requests issue until the next redirect.
  - The RESET_PC alignment check applies identically at reset release.
- IF_ALIGN_CHECK_EN undefined:
  - out_adel does not exist.
  - redirect_pc[1:0] is ignored; imem_addr is forced to {redirect_pc[ADDR_W-1:2],2'b00}.

## Test plan
- Reset release, imem_ack=1, out_ready=1, mem[i]=i → out_pc 0,4,8,… with out_inst 0,1,2,… starting 1 cycle after first transfer, one per cycle.
- out_ready=0 for 10 cycles → exactly DEPTH(4) transfers, imem_req low. Then out_ready=1 → entries drain in order with no loss or duplication.
- imem_ack held low 3 cycles → imem_req/imem_addr=0x0 stable. Ack on 4th cycle → single push of PC 0x0.
- Redirect to 0x100 with 3 entries buffered, out_ready=1 → next cycle out_valid=0. Following out_pc sequence 0x100, 0x104; stale entries never appear.
- Redirect coincident with pop and full FIFO → FIFO empty next cycle and imem_addr=redirect_pc.
- (IF_ALIGN_CHECK_EN) redirect to 0x102 → one entry out_pc=0x102, out_inst=0, out_adel=1. Then no requests until redirect to 0x200 resumes fetch.
